// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the round-robin counter scheduler.
// Holds the state encoding, default sizes and the one-hot decode helper.
package counter_sched_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int ONEHOT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Wide enough for the largest supported requester count; callers slice it down.
  function automatic logic [ONEHOT_W-1:0] onehot(input int idx);
    return ONEHOT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/counter_sched_rr_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// The pointer register itself lives in the scheduler top.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [2*N_REQ-1:0] rot;
  int                 pos;

  assign rot = {req, req} >> ptr;

  // Scan from the far end so the closest set bit to ptr is written last and wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    pos    = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos = int'(ptr) + i;
        if (pos >= N_REQ) pos = pos - N_REQ;
        winner = IDX_W'(pos);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_sched_rr.sv
// Round-robin scheduler sharing one up-counter among N_REQ requesters.
// The winner is counted 0..len, then receives a one-cycle done pulse.
module counter_sched_rr
  import counter_sched_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] len,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       cnt
);

  state_t             state_q, state_n;
  logic [N_REQ-1:0]   gnt_q, gnt_n;
  logic [N_REQ-1:0]   done_q, done_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [CNT_W-1:0]   target_q, target_n;
  logic [IDX_W-1:0]   ptr_q, ptr_n;
  logic [IDX_W-1:0]   cur_q, cur_n;
  logic [IDX_W-1:0]   win;
  logic               win_valid;
  logic [IDX_W-1:0]   ptr_after_cur;
  logic [ONEHOT_W-1:0] win_oh, cur_oh;
  logic [CNT_W-1:0]   len_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_len
    assign len_arr[g] = len[g*CNT_W +: CNT_W];
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .winner (win),
    .valid  (win_valid)
  );

  assign win_oh        = onehot(int'(win));
  assign cur_oh        = onehot(int'(cur_q));
  assign ptr_after_cur = (cur_q == IDX_W'(N_REQ - 1)) ? '0 : cur_q + 1'b1;

  always_comb begin
    state_n  = state_q;
    gnt_n    = gnt_q;
    done_n   = '0;
    cnt_n    = cnt_q;
    target_n = target_q;
    ptr_n    = ptr_q;
    cur_n    = cur_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_n  = COUNT;
          gnt_n    = win_oh[N_REQ-1:0];
          cnt_n    = '0;
          target_n = len_arr[win];
          cur_n    = win;
        end
      end
      COUNT: begin
        if (!req[cur_q]) begin
          // Aborted job: release the timer without a completion pulse.
          state_n = IDLE;
          gnt_n   = '0;
          cnt_n   = '0;
          ptr_n   = ptr_after_cur;
        end else if (cnt_q == target_q) begin
          state_n = DONE;
          gnt_n   = '0;
          done_n  = cur_oh[N_REQ-1:0];
          ptr_n   = ptr_after_cur;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      ptr_q    <= '0;
      cur_q    <= '0;
    end else begin
      state_q  <= state_n;
      gnt_q    <= gnt_n;
      done_q   <= done_n;
      cnt_q    <= cnt_n;
      target_q <= target_n;
      ptr_q    <= ptr_n;
      cur_q    <= cur_n;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign cnt  = cnt_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_counter_sched_rr.sv
// Bench for counter_sched_rr: directed scenarios plus randomized traffic,
// every cycle compared against a job-level reference model.
module tb_counter_sched_rr;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N*W-1:0] len;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic         busy;
  logic [W-1:0] cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: job-level view (who holds the timer and how far along).
  bit job_active;   // a requester currently owns the timer
  bit job_finished; // completion pulse cycle
  int job_owner;
  int job_elapsed;
  int job_length;
  int next_first;   // where the next round-robin search starts

  counter_sched_rr #(.N_REQ(N), .CNT_W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .cnt  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_len(input int i, input int v);
    len[i*W +: W] = W'(v);
  endtask

  task automatic model_step();
    bit found;
    int cand;
    if (rst) begin
      job_active = 0; job_finished = 0; job_elapsed = 0; next_first = 0;
    end else if (job_finished) begin
      job_finished = 0; job_elapsed = 0;
    end else if (job_active) begin
      if (!req[job_owner]) begin
        job_active = 0; job_elapsed = 0; next_first = (job_owner + 1) % N;
      end else if (job_elapsed == job_length) begin
        job_active = 0; job_finished = 1; next_first = (job_owner + 1) % N;
      end else begin
        job_elapsed++;
      end
    end else if (req != 0) begin
      found = 0;
      for (int o = 0; o < N; o++) begin
        cand = (next_first + o) % N;
        if (!found && req[cand]) begin
          found = 1; job_owner = cand;
        end
      end
      job_active  = 1;
      job_elapsed = 0;
      job_length  = int'(len[job_owner*W +: W]);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_gnt, e_done;
    logic         e_busy;
    logic [W-1:0] e_cnt;
    e_gnt  = job_active   ? N'(1 << job_owner) : '0;
    e_done = job_finished ? N'(1 << job_owner) : '0;
    e_busy = job_active || job_finished;
    e_cnt  = W'(job_elapsed);
    checks++;
    assert (gnt === e_gnt) else begin
      failures++; $error("FAIL gnt t=%0t got=%b exp=%b", $time, gnt, e_gnt);
    end
    checks++;
    assert (done === e_done) else begin
      failures++; $error("FAIL done t=%0t got=%b exp=%b", $time, done, e_done);
    end
    checks++;
    assert (busy === e_busy) else begin
      failures++; $error("FAIL busy t=%0t got=%b exp=%b", $time, busy, e_busy);
    end
    checks++;
    assert (cnt === e_cnt) else begin
      failures++; $error("FAIL cnt t=%0t got=%0d exp=%0d", $time, cnt, e_cnt);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Registered requesters clear req at the edge that ends their done pulse.
  task automatic drop_on_done();
    if (job_finished) req[job_owner] = 1'b0;
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    int order[$];
    int last, n0, n2, alt_bad, gcycles, dcount, maxcnt, bound, v;
    logic [N-1:0] prev_gnt;

    job_active = 0; job_finished = 0; job_owner = 0;
    job_elapsed = 0; job_length = 0; next_first = 0;

    // Reset held with all requests pending, all lengths zero.
    rst = 1'b1; req = 4'b1111; len = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    assert (gnt === 4'b0001) else begin
      failures++; $error("FAIL first_grant got=%b exp=0001", gnt);
    end

    // Simultaneous zero-length jobs: expect order 0,1,2,3.
    order.push_back(idx_of(gnt));
    prev_gnt = gnt;
    bound = 0;
    while (req != 0 && bound < 40) begin
      drop_on_done();
      tick();
      if (gnt != 0 && prev_gnt == 0) order.push_back(idx_of(gnt));
      prev_gnt = gnt;
      bound++;
    end
    checks++;
    assert (order.size() == 4) else begin
      failures++; $error("FAIL order_len got=%0d exp=4", order.size());
    end
    for (int i = 0; i < order.size() && i < 4; i++) begin
      checks++;
      assert (order[i] == i) else begin
        failures++; $error("FAIL order[%0d] got=%0d exp=%0d", i, order[i], i);
      end
    end
    tick(); tick();

    // Single job of length 3 on requester 0.
    set_len(0, 3); req = 4'b0001;
    gcycles = 0; bound = 0;
    while (req != 0 && bound < 20) begin
      drop_on_done();
      tick();
      if (gnt == 4'b0001) gcycles++;
      bound++;
    end
    checks++;
    assert (gcycles == 4) else begin
      failures++; $error("FAIL single_gnt_cycles got=%0d exp=4", gcycles);
    end
    tick(); tick();

    // Fairness: 0 and 2 keep requesting with length 1.
    set_len(0, 1); set_len(2, 1); req = 4'b0101;
    prev_gnt = '0; last = -1; n0 = 0; n2 = 0; alt_bad = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (gnt != 0 && prev_gnt == 0) begin
        v = idx_of(gnt);
        if (v == last) alt_bad++;
        if (v == 0) n0++;
        if (v == 2) n2++;
        last = v;
      end
      prev_gnt = gnt;
    end
    checks++;
    assert (alt_bad == 0 && n0 >= 5 && n2 >= 5) else begin
      failures++; $error("FAIL fairness got n0=%0d n2=%0d repeats=%0d exp alternating", n0, n2, alt_bad);
    end
    req = '0;
    tick(); tick(); tick();

    // Maximum length on requester 3.
    set_len(3, 255); req = 4'b1000;
    gcycles = 0; dcount = 0; maxcnt = 0; bound = 0;
    while (req != 0 && bound < 300) begin
      drop_on_done();
      tick();
      if (gnt == 4'b1000) gcycles++;
      if (done != 0) dcount++;
      if (int'(cnt) > maxcnt) maxcnt = int'(cnt);
      bound++;
    end
    checks++;
    assert (gcycles == 256 && dcount == 1 && maxcnt == 255) else begin
      failures++; $error("FAIL maxlen got gnt=%0d done=%0d maxcnt=%0d exp 256/1/255", gcycles, dcount, maxcnt);
    end
    tick(); tick();

    // Abort requester 1 at cnt=4 while 0 and 2 wait; next grant must be 2.
    set_len(1, 10); set_len(0, 2); set_len(2, 2); req = 4'b0010;
    bound = 0;
    do begin tick(); bound++; end while (!(job_active && job_elapsed == 4) && bound < 20);
    req = 4'b0101;
    tick();
    checks++;
    assert (gnt === 4'b0000 && cnt === 8'd0 && done === 4'b0000) else begin
      failures++; $error("FAIL abort got gnt=%b cnt=%0d done=%b exp 0000/0/0000", gnt, cnt, done);
    end
    tick();
    checks++;
    assert (gnt === 4'b0100) else begin
      failures++; $error("FAIL after_abort got=%b exp=0100", gnt);
    end
    bound = 0;
    while (req != 0 && bound < 30) begin drop_on_done(); tick(); bound++; end
    tick(); tick();

    // Reset during a count at cnt=5; ptr must restart at 0.
    set_len(2, 9); req = 4'b0100;
    bound = 0;
    do begin tick(); bound++; end while (!(job_active && job_elapsed == 5) && bound < 20);
    set_len(0, 1);
    rst = 1'b1;
    tick();
    checks++;
    assert (gnt === 4'b0000 && cnt === 8'd0 && busy === 1'b0 && done === 4'b0000) else begin
      failures++; $error("FAIL mid_reset got gnt=%b cnt=%0d busy=%b done=%b", gnt, cnt, busy, done);
    end
    rst = 1'b0; req = 4'b0101;
    tick();
    checks++;
    assert (gnt === 4'b0001) else begin
      failures++; $error("FAIL post_reset_grant got=%b exp=0001", gnt);
    end
    bound = 0;
    while (req != 0 && bound < 30) begin drop_on_done(); tick(); bound++; end

    // Randomized traffic with aborts and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst = 1'b0;
      drop_on_done();
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 15) == 0) set_len(i, $urandom_range(0, 40));
          else set_len(i, $urandom_range(0, 6));
          req[i] = 1'b1;
        end
      end
      if (job_active && $urandom_range(0, 39) == 0) req[job_owner] = 1'b0;
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_sched_rr.md
Name: counter_sched_rr

Overview:
- Round-robin scheduler that shares one up-counter timer among N_REQ requesters.
- A requester asks for a count of length len. The scheduler grants the timer to the winner, then counts 0..len.
- It pulses done to that requester, then re-arbitrates.
- It sits between the client blocks and the shared counter datapath and owns that counter's load/enable sequencing.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- CNT_W, 8, counter and length width in bits

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  N_REQ  level request per requester; held until done or deliberately dropped (abort)
- len  input  N_REQ*CNT_W  packed lengths; requester i uses bits [i*CNT_W +: CNT_W]; must be stable while req[i] is high
- gnt  output  N_REQ  one-hot grant, registered; all-zero when idle
- done  output  N_REQ  one-hot, one-cycle completion pulse, registered
- busy  output  1  high in COUNT and DONE states
- cnt  output  CNT_W  current counter value, registered

Behaviour:
- Reset: state=IDLE, gnt=0, done=0, busy=0, cnt=0, target=0, rr pointer ptr=0. Reset asserted in any state returns everything to these values at the next edge; no done pulse is issued for an interrupted job.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise the winner w is the first set bit searching ptr, ptr+1, ..., wrapping mod N_REQ.
  - At the edge: state=COUNT, gnt=onehot(w), cnt=0, target=len[w].
- COUNT:
  - If req[w]==0 (abort): state=IDLE, gnt=0, cnt=0, ptr=(w+1) mod N_REQ, no done.
  - Else if cnt==target: state=DONE, gnt=0, done=onehot(w), ptr=(w+1) mod N_REQ; cnt holds target.
  - Else cnt=cnt+1.
- DONE: lasts exactly one cycle. At the edge: done=0, cnt=0, state=IDLE.
- Timing for a job of length L:
  - Arbitration happens in the cycle before gnt rises.
  - gnt is high for L+1 cycles, with cnt=0..L.
  - The done pulse follows in the next cycle, then one IDLE cycle.
  - Minimum job period is therefore L+3 cycles.
- Width rules: cnt never wraps because it stops at target. len=2^CNT_W-1 is legal (cnt reaches all-ones). len=0 gives a one-cycle grant.
- Requesters with a registered req react to done by clearing req at the edge that ends DONE, so they are not re-granted in the following IDLE cycle.
- Requests that rise while COUNT is active are only considered at the next IDLE arbitration.
- len changes on non-granted requesters are ignored. target is captured only at grant.
- Invariants: gnt and done are each one-hot or zero and never both nonzero; busy equals (state!=IDLE).

Decomposition:
- Shared package counter_sched_pkg:
  - state enum (IDLE=2'd0, COUNT=2'd1, DONE=2'd2)
  - localparam defaults for N_REQ and CNT_W
  - function onehot(idx)
- Sub-module rr_arbiter:
  - Combinational round-robin pick from req and ptr.
  - Outputs: winner index, valid.
  - Pointer register stays in the top level.

Test Plan:
- Reset: assert rst 2 cycles with req=4'b1111 -> gnt=0, done=0, busy=0, cnt=0 throughout; first grant is to requester 0 one cycle after rst drops.
- Single job: req=4'b0001, len0=3 -> gnt=0001 for 4 cycles with cnt=0,1,2,3; done=0001 for 1 cycle; busy low on the next cycle; req dropped on done.
- Simultaneous: all req high from reset, all len=0, each requester drops on its done -> grant order 0,1,2,3; each gnt 1 cycle; done on the next cycle; 3-cycle period per job.
- Fairness and max length:
  - req0 and req2 re-request forever, len=1 -> grants alternate 0,2,0,2; neither is starved.
  - len=255 on requester 3 -> cnt reaches 255, no wrap, gnt high 256 cycles, single done.
- Abort: req1 with len=10, drop req1 while cnt=4 -> gnt=0 and cnt=0 at the next edge, no done; with req2 and req0 pending, next grant goes to 2 (ptr=2).
- Reset mid-operation: rst during COUNT at cnt=5 -> next cycle gnt=0, cnt=0, busy=0, done=0; after release, arbitration restarts from ptr=0.
